// File: rtl/mul_pkg.sv
// Shared types and constants for the MIPS32 sequential multiplier (mul_unit).
package mul_pkg;

    localparam int unsigned MUL_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2
    } mul_state_e;

    // Multiplier-related operation encodings driven by the control unit.
    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_MTHI  = 2'd2,
        OP_MTLO  = 2'd3
    } mul_op_e;

endpackage

// File: rtl/mul_step.sv
// One shift-and-add iteration of the unsigned magnitude multiplier (combinational).
module mul_step
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [2*WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0]   mplier_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic [2*WIDTH-1:0] mcand_o,
    output logic [WIDTH-1:0]   mplier_o
);

    always_comb begin
        acc_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
        mcand_o  = mcand_i << 1;
        mplier_o = mplier_i >> 1;
    end

endmodule

// File: rtl/mul_unit.sv
// Sequential 32x32 MULT/MULTU unit with architectural HI/LO registers.
// Optional MUL_EARLY_EXIT_EN: leave RUN as soon as the remaining multiplier is zero.
module mul_unit
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mul_state_e           state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic [2*WIDTH-1:0]   step_acc, step_mcand;
    logic [WIDTH-1:0]     step_mplier;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [2*WIDTH-1:0]   product;

    mul_step #(.WIDTH(WIDTH)) u_step (
        .acc_i    (acc_q),
        .mcand_i  (mcand_q),
        .mplier_i (mplier_q),
        .acc_o    (step_acc),
        .mcand_o  (step_mcand),
        .mplier_o (step_mplier)
    );

    // 0x80000000 negates to itself, which read unsigned is the correct magnitude.
    always_comb begin
        mag_a   = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
        mag_b   = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
        product = neg_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;

        unique case (state_q)
            IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, mag_a};
                    mplier_d = mag_b;
                    neg_d    = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
`ifdef MUL_EARLY_EXIT_EN
                if (mplier_q == '0) begin
                    state_d = SIGN;
                end else begin
                    acc_d    = step_acc;
                    mcand_d  = step_mcand;
                    mplier_d = step_mplier;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = SIGN;
                end
`else
                acc_d    = step_acc;
                mcand_d  = step_mcand;
                mplier_d = step_mplier;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = SIGN;
`endif
            end
            SIGN: begin
                {hi_d, lo_d} = product;
                done_d       = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
        acc_q    <= acc_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        cnt_q    <= cnt_d;
        neg_q    <= neg_d;
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
